// File: rtl/apb_gpio_debounce.sv
// APB3 GPIO slave: per-channel 2-flop synchroniser, debounce counter, edge-triggered maskable irq.
// Optional PWM dimming of gpio_out is compiled in with `define APB_GPIO_PWM_EN.
module apb_gpio_debounce #(
    parameter int GPIO_WIDTH      = 16,
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int ADDR_WIDTH      = 32
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic [ADDR_WIDTH-1:0] s_apb_paddr,
    input  logic                  s_apb_psel,
    input  logic                  s_apb_penable,
    input  logic                  s_apb_pwrite,
    input  logic [31:0]           s_apb_pwdata,
    output logic                  s_apb_pready,
    output logic [31:0]           s_apb_prdata,
    output logic                  s_apb_pslverror,
    input  logic [GPIO_WIDTH-1:0] gpio_in,
    output logic [GPIO_WIDTH-1:0] gpio_out,
    output logic                  irq
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    localparam logic [2:0] OFF_OUT    = 3'd0;
    localparam logic [2:0] OFF_IN     = 3'd1;
    localparam logic [2:0] OFF_IRQ_EN = 3'd2;
    localparam logic [2:0] OFF_STATUS = 3'd3;
    localparam logic [2:0] OFF_RISE   = 3'd4;
    localparam logic [2:0] OFF_FALL   = 3'd5;
`ifdef APB_GPIO_PWM_EN
    localparam logic [2:0] OFF_PWM    = 3'd6;
`endif

    logic [2:0]            word_sel;
    logic                  setup_ph;
    logic                  wr_commit;
    logic [GPIO_WIDTH-1:0] wdata_g;
    logic                  unused_bits;

    assign word_sel    = s_apb_paddr[4:2];
    assign setup_ph    = s_apb_psel & ~s_apb_penable;
    assign wr_commit   = s_apb_psel & s_apb_penable & s_apb_pwrite;
    assign wdata_g     = s_apb_pwdata[GPIO_WIDTH-1:0];
    assign unused_bits = ^{s_apb_paddr, s_apb_pwdata};

    logic [GPIO_WIDTH-1:0] out_reg;
    logic [GPIO_WIDTH-1:0] irq_en_reg;
    logic [GPIO_WIDTH-1:0] status_reg;
    logic [GPIO_WIDTH-1:0] status_next;
    logic [GPIO_WIDTH-1:0] rise_en_reg;
    logic [GPIO_WIDTH-1:0] fall_en_reg;
    logic [GPIO_WIDTH-1:0] stable_vec;
    logic [GPIO_WIDTH-1:0] stable_prev_reg;
    logic                  irq_reg;
    logic [31:0]           prdata_reg;
    logic [31:0]           rdata_next;
    logic                  pslverror_reg;
    logic                  err_next;

    // Per-channel synchroniser and debounce: stable only follows after
    // DEBOUNCE_CYCLES consecutive synchronised samples disagree with it.
    genvar gi;
    generate
        for (gi = 0; gi < GPIO_WIDTH; gi++) begin : g_ch
            logic             sync1_reg;
            logic             sync2_reg;
            logic             stable_reg;
            logic [CNT_W-1:0] cnt_reg;

            always_ff @(posedge clk or negedge resetn) begin
                if (!resetn) begin
                    sync1_reg  <= 1'b0;
                    sync2_reg  <= 1'b0;
                    stable_reg <= 1'b0;
                    cnt_reg    <= '0;
                end else begin
                    sync1_reg <= gpio_in[gi];
                    sync2_reg <= sync1_reg;
                    if (sync2_reg == stable_reg) begin
                        cnt_reg <= '0;
                    end else if (cnt_reg == CNT_MAX) begin
                        cnt_reg    <= '0;
                        stable_reg <= sync2_reg;
                    end else begin
                        cnt_reg <= cnt_reg + CNT_W'(1);
                    end
                end
            end

            assign stable_vec[gi] = stable_reg;
        end
    endgenerate

`ifdef APB_GPIO_PWM_EN
    logic [7:0]            pwm_duty_reg;
    logic                  pwm_bypass_reg;
    logic [7:0]            pwm_cnt_reg;
    logic [GPIO_WIDTH-1:0] pwm_out_reg;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            pwm_duty_reg   <= 8'd0;
            pwm_bypass_reg <= 1'b1;
            pwm_cnt_reg    <= 8'd0;
            pwm_out_reg    <= '0;
        end else begin
            pwm_cnt_reg <= pwm_cnt_reg + 8'd1;
            pwm_out_reg <= out_reg & {GPIO_WIDTH{pwm_cnt_reg < pwm_duty_reg}};
            if (wr_commit && word_sel == OFF_PWM) begin
                pwm_duty_reg   <= s_apb_pwdata[7:0];
                pwm_bypass_reg <= s_apb_pwdata[8];
            end
        end
    end

    // Duty 0 with bypass set hands the outputs straight to the OUT register.
    assign gpio_out = (pwm_duty_reg == 8'd0 && pwm_bypass_reg) ? out_reg : pwm_out_reg;
`else
    assign gpio_out = out_reg;
`endif

    // Edge events set status; a same-cycle W1C loses to a new event.
    always_comb begin
        logic [GPIO_WIDTH-1:0] rise_evt;
        logic [GPIO_WIDTH-1:0] fall_evt;
        logic [GPIO_WIDTH-1:0] w1c_mask;
        rise_evt = stable_vec & ~stable_prev_reg;
        fall_evt = ~stable_vec & stable_prev_reg;
        w1c_mask = '0;
        if (wr_commit && word_sel == OFF_STATUS) begin
            w1c_mask = wdata_g;
        end
        status_next = (status_reg & ~w1c_mask)
                    | (rise_evt & rise_en_reg)
                    | (fall_evt & fall_en_reg);
    end

    always_comb begin
        rdata_next = 32'd0;
        err_next   = 1'b0;
        case (word_sel)
            OFF_OUT:    rdata_next = 32'(out_reg);
            OFF_IN:     rdata_next = 32'(stable_vec);
            OFF_IRQ_EN: rdata_next = 32'(irq_en_reg);
            OFF_STATUS: rdata_next = 32'(status_reg);
            OFF_RISE:   rdata_next = 32'(rise_en_reg);
            OFF_FALL:   rdata_next = 32'(fall_en_reg);
`ifdef APB_GPIO_PWM_EN
            OFF_PWM:    rdata_next = 32'({pwm_bypass_reg, pwm_duty_reg});
`endif
            default:    err_next = 1'b1;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            out_reg         <= '0;
            irq_en_reg      <= '0;
            status_reg      <= '0;
            rise_en_reg     <= '0;
            fall_en_reg     <= '0;
            stable_prev_reg <= '0;
            irq_reg         <= 1'b0;
            prdata_reg      <= 32'd0;
            pslverror_reg   <= 1'b0;
        end else begin
            status_reg      <= status_next;
            stable_prev_reg <= stable_vec;
            irq_reg         <= |(status_reg & irq_en_reg);
            // Response is captured in setup and held through the access phase.
            if (setup_ph) begin
                prdata_reg    <= rdata_next;
                pslverror_reg <= err_next;
            end
            if (wr_commit) begin
                case (word_sel)
                    OFF_OUT:    out_reg     <= wdata_g;
                    OFF_IRQ_EN: irq_en_reg  <= wdata_g;
                    OFF_RISE:   rise_en_reg <= wdata_g;
                    OFF_FALL:   fall_en_reg <= wdata_g;
                    default:    ;
                endcase
            end
        end
    end

    assign s_apb_pready    = s_apb_psel & s_apb_penable;
    assign s_apb_prdata    = prdata_reg;
    assign s_apb_pslverror = pslverror_reg;
    assign irq             = irq_reg;

endmodule

// File: tb/tb_apb_gpio_debounce.sv
// Scoreboarded bench for apb_gpio_debounce with a window-based debounce reference model.
`timescale 1ns/1ps
module tb_apb_gpio_debounce;

    localparam int W  = 16;
    localparam int DC = 4;

    logic          clk = 1'b0;
    logic          resetn = 1'b0;
    logic [31:0]   paddr = 32'd0;
    logic          psel = 1'b0;
    logic          penable = 1'b0;
    logic          pwrite = 1'b0;
    logic [31:0]   pwdata = 32'd0;
    logic          pready;
    logic [31:0]   prdata;
    logic          pslverror;
    logic [W-1:0]  gpio_in = '0;
    logic [W-1:0]  gpio_out;
    logic          irq;

    always #5 clk = ~clk;

    apb_gpio_debounce #(
        .GPIO_WIDTH(W),
        .DEBOUNCE_CYCLES(DC),
        .ADDR_WIDTH(32)
    ) dut (
        .clk(clk),
        .resetn(resetn),
        .s_apb_paddr(paddr),
        .s_apb_psel(psel),
        .s_apb_penable(penable),
        .s_apb_pwrite(pwrite),
        .s_apb_pwdata(pwdata),
        .s_apb_pready(pready),
        .s_apb_prdata(prdata),
        .s_apb_pslverror(pslverror),
        .gpio_in(gpio_in),
        .gpio_out(gpio_out),
        .irq(irq)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference model: stable flips once the last DC synchronised samples
    // (pins sampled 2..DC+1 edges ago) all disagree with it.
    logic [W-1:0] out_m, stable_m, prev_m, irq_en_m, status_m, rise_m, fall_m;
    logic         irq_m;
    logic [7:0]   duty_m;
    logic         bypass_m;
    logic [W-1:0] pin_hist [DC+2];

    always @(posedge clk or negedge resetn) begin
        logic [W-1:0] set_m, w1c_m, all_diff;
        logic         wr;
        logic [2:0]   off;
        if (!resetn) begin
            out_m = '0; stable_m = '0; prev_m = '0; irq_en_m = '0;
            status_m = '0; rise_m = '0; fall_m = '0; irq_m = 1'b0;
            duty_m = 8'd0; bypass_m = 1'b1;
            for (int j = 0; j < DC + 2; j++) pin_hist[j] = '0;
        end else begin
            wr  = psel && penable && pwrite;
            off = paddr[4:2];
            irq_m = |(status_m & irq_en_m);
            set_m = (stable_m & ~prev_m & rise_m) | (~stable_m & prev_m & fall_m);
            w1c_m = (wr && off == 3'd3) ? pwdata[W-1:0] : '0;
            status_m = (status_m & ~w1c_m) | set_m;
            prev_m = stable_m;
            for (int j = DC + 1; j > 0; j--) pin_hist[j] = pin_hist[j-1];
            pin_hist[0] = gpio_in;
            all_diff = '1;
            for (int j = 2; j <= DC + 1; j++) all_diff &= pin_hist[j] ^ stable_m;
            stable_m ^= all_diff;
            if (wr) begin
                case (off)
                    3'd0: out_m    = pwdata[W-1:0];
                    3'd2: irq_en_m = pwdata[W-1:0];
                    3'd4: rise_m   = pwdata[W-1:0];
                    3'd5: fall_m   = pwdata[W-1:0];
                    3'd6: begin duty_m = pwdata[7:0]; bypass_m = pwdata[8]; end
                    default: ;
                endcase
            end
        end
    end

    function automatic logic exp_err(input logic [2:0] off);
`ifdef APB_GPIO_PWM_EN
        return off == 3'd7;
`else
        return off >= 3'd6;
`endif
    endfunction

    function automatic logic [31:0] exp_rdata(input logic [2:0] off);
        case (off)
            3'd0: return 32'(out_m);
            3'd1: return 32'(stable_m);
            3'd2: return 32'(irq_en_m);
            3'd3: return 32'(status_m);
            3'd4: return 32'(rise_m);
            3'd5: return 32'(fall_m);
`ifdef APB_GPIO_PWM_EN
            3'd6: return 32'({bypass_m, duty_m});
`endif
            default: return 32'd0;
        endcase
    endfunction

    typedef struct {
        logic        chk;
        logic [31:0] data;
        logic        err;
    } exp_t;
    exp_t sb[$];

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic apb_write(input logic [31:0] a, input logic [31:0] d);
        exp_t e;
        e.chk = 1'b0; e.data = 32'd0; e.err = exp_err(a[4:2]);
        sb.push_back(e);
        $display("APB WR addr=0x%02h data=0x%08h", a[7:0], d);
        paddr = a; pwdata = d; pwrite = 1'b1; psel = 1'b1; penable = 1'b0;
        @(posedge clk); #1 penable = 1'b1;
        @(posedge clk); #1 psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
    endtask

    task automatic apb_read_exp(input logic [31:0] a, input logic [31:0] exp);
        exp_t e;
        e.chk = 1'b1; e.data = exp; e.err = exp_err(a[4:2]);
        sb.push_back(e);
        $display("APB RD addr=0x%02h expect=0x%08h", a[7:0], exp);
        paddr = a; pwrite = 1'b0; psel = 1'b1; penable = 1'b0;
        @(posedge clk); #1 penable = 1'b1;
        @(posedge clk); #1 psel = 1'b0; penable = 1'b0;
    endtask

    task automatic apb_read(input logic [31:0] a);
        apb_read_exp(a, exp_rdata(a[4:2]));
    endtask

    // Monitor: pops one expectation per access phase; also tracks irq/gpio_out each cycle.
    always @(negedge clk) begin
        exp_t e;
        if (resetn && psel && penable) begin
            check("pready", 32'(pready), 32'd1);
            if (sb.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL sb_underflow: got access phase, expected none");
            end else begin
                e = sb.pop_front();
                if (e.chk) check("rd_data", prdata, e.data);
                check("pslverror", 32'(pslverror), 32'(e.err));
            end
        end
        if (resetn) begin
            check("irq", 32'(irq), 32'(irq_m));
`ifndef APB_GPIO_PWM_EN
            check("gpio_out", 32'(gpio_out), 32'(out_m));
`endif
        end
    end

    initial begin
        #1ms;
        $display("FAIL watchdog: got timeout, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int hi, other;
        repeat (3) @(posedge clk);
        #1 resetn = 1'b1;
        check("irq_rst", 32'(irq), 32'd0);
        check("gpio_out_rst", 32'(gpio_out), 32'd0);
        for (int o = 0; o < 6; o++) apb_read_exp(32'(o * 4), 32'd0);

        apb_write(32'h00, 32'h0000_A5A5);
        check("gpio_out_wr", 32'(gpio_out), 32'h0000_A5A5);
        apb_read_exp(32'h00, 32'h0000_A5A5);

        // Held rise on ch0: stable at +6, status at +7, irq at +8
        apb_write(32'h10, 32'h1);
        apb_write(32'h08, 32'h1);
        gpio_in[0] = 1'b1;
        tick(7);
        check("irq_before_latency", 32'(irq), 32'd0);
        tick(1);
        check("irq_at_latency", 32'(irq), 32'd1);
        apb_read_exp(32'h0C, 32'h1);
        apb_write(32'h0C, 32'h1);
        check("irq_after_w1c_edge", 32'(irq), 32'd1);
        tick(1);
        check("irq_cleared", 32'(irq), 32'd0);

        // Short pulse on ch1 never reaches IN
        gpio_in[1] = 1'b1;
        tick(3);
        gpio_in[1] = 1'b0;
        tick(10);
        apb_read_exp(32'h04, 32'h1);

        // Fall on ch2 masked, then enabled (irq stays low: IRQ_EN[2]=0)
        gpio_in[2] = 1'b1;
        tick(10);
        apb_write(32'h0C, 32'hFFFF);
        gpio_in[2] = 1'b0;
        tick(10);
        apb_read_exp(32'h0C, 32'h0);
        apb_write(32'h14, 32'h4);
        gpio_in[2] = 1'b1;
        tick(10);
        gpio_in[2] = 1'b0;
        tick(10);
        apb_read_exp(32'h0C, 32'h4);
        check("irq_masked", 32'(irq), 32'd0);

        // Edge set on ch3 lands on the same edge as a W1C of bit 3
        apb_write(32'h10, 32'h9);
        apb_write(32'h0C, 32'hFFFF);
        gpio_in[3] = 1'b1;
        tick(5);
        apb_write(32'h0C, 32'h8);
        apb_read_exp(32'h0C, 32'h8);

        apb_read_exp(32'h1C, 32'h0);
        apb_read(32'h18);
        apb_write(32'h18, 32'h100);
        apb_write(32'h1C, 32'h1234);
        apb_write(32'h04, 32'hFFFF);
        apb_read(32'h04);

`ifdef APB_GPIO_PWM_EN
        apb_write(32'h00, 32'hFFFF);
        apb_write(32'h18, 32'd64);
        tick(300);
        hi = 0; other = 0;
        for (int c = 0; c < 256; c++) begin
            @(negedge clk);
            if (gpio_out == 16'hFFFF) hi++;
            else if (gpio_out != 16'h0) other++;
        end
        #1;
        check("pwm_on_cycles", 32'(hi), 32'd64);
        check("pwm_partial", 32'(other), 32'd0);
        tick(1);
        apb_write(32'h18, 32'h100);
`endif

        for (int it = 0; it < 400; it++) begin
            case ($urandom_range(0, 6))
                0, 1: begin
                    gpio_in = gpio_in ^ W'($urandom);
                    $display("PIN gpio_in=0x%04h", gpio_in);
                    tick($urandom_range(1, 8));
                end
                2, 3: apb_read({27'd0, 3'($urandom_range(0, 7)), 2'b00});
                4: apb_write({27'd0, 3'($urandom_range(0, 7)), 2'b00}, $urandom);
                5: apb_write(32'h0C, $urandom);
                default: tick($urandom_range(1, 12));
            endcase
        end

        // Asynchronous reset in the middle of a debounce
        gpio_in = W'($urandom) | 16'h0001;
        tick(2);
        #2 resetn = 1'b0;
        tick(2);
        resetn = 1'b1;
        check("irq_midrst", 32'(irq), 32'd0);
        check("gpio_out_midrst", 32'(gpio_out), 32'd0);
        for (int o = 0; o < 6; o++) apb_read(32'(o * 4));
        tick(20);
        apb_read(32'h04);
        apb_read(32'h0C);

        tick(5);
        check("sb_empty", 32'(sb.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/apb_gpio_debounce.md
Name: apb_gpio_debounce

Overview:
Parametrised APB3 slave GPIO block for board I/O such as slide switches and LEDs. Each input channel gets a 2-flop synchroniser and a per-channel debounce counter. Debounced edges are detected per channel and feed a maskable level interrupt. Sits on the SoC APB master port between the core and board pins; GPIO_WIDTH generalises the fixed 16-bit switch/LED banks.

Parameters:
GPIO_WIDTH, 16, number of input and output channels (1..32)
DEBOUNCE_CYCLES, 1000000, consecutive clk cycles a synchronised input must differ from its stable value before the stable value updates (>=2)
ADDR_WIDTH, 32, APB address width; only paddr[4:2] are decoded

Ports:
clk  in  1  system clock
resetn  in  1  asynchronous active-low reset
s_apb_paddr  in  ADDR_WIDTH  APB address
s_apb_psel  in  1  APB select
s_apb_penable  in  1  APB enable (access phase)
s_apb_pwrite  in  1  1=write, 0=read
s_apb_pwdata  in  32  write data
s_apb_pready  out  1  transfer complete
s_apb_prdata  out  32  read data
s_apb_pslverror  out  1  unmapped-address error
gpio_in  in  GPIO_WIDTH  raw asynchronous inputs (switches)
gpio_out  out  GPIO_WIDTH  outputs (LEDs)
irq  out  1  level interrupt, active high

Behaviour:
- Reset: all registers, counters, synchronisers, stable values, prdata, pslverror and gpio_out go to 0; irq goes to 0.
- Register map (word offsets, paddr[4:2]); bits above GPIO_WIDTH read 0 and ignore writes:
  - 0x00 OUT: RW, drives gpio_out.
  - 0x04 IN: RO, debounced stable value.
  - 0x08 IRQ_EN: RW.
  - 0x0C IRQ_STATUS: read returns status; write-1-to-clear.
  - 0x10 RISE_EN: RW.
  - 0x14 FALL_EN: RW.
  - 0x18 PWM_DUTY: only exists with the optional feature.
  - Any other offset is unmapped.
- APB timing:
  - pready = psel & penable (zero wait states).
  - prdata and pslverror are registered during the setup phase (psel & !penable) and held through the access phase. Unmapped reads return 0.
  - A write commits on the clk edge where psel & penable & pwrite. Unmapped writes have no effect and assert pslverror.
  - Writes to 0x04 are ignored with no error.
- Synchroniser: 2 flops per channel.
- Debounce (per channel):
  - Counter width is clog2(DEBOUNCE_CYCLES).
  - If the synchronised value equals the stable value, the counter resets to 0.
  - Otherwise the counter increments. On reaching DEBOUNCE_CYCLES-1 it resets to 0 and the stable value takes the synchronised value.
  - Total latency from a held pin change to the IN update is DEBOUNCE_CYCLES+2 cycles.
  - A glitch shorter than DEBOUNCE_CYCLES synchronised cycles never changes the stable value.
- Edge detection: a stable 0->1 on channel i with RISE_EN[i]=1, or 1->0 with FALL_EN[i]=1, sets IRQ_STATUS[i] on the following edge. Status is set regardless of IRQ_EN.
- Simultaneous events: an edge-set and a W1C on the same bit in the same cycle leave the bit set (set wins).
- irq is registered: irq <= |(IRQ_STATUS & IRQ_EN). It rises 1 cycle after the status or enable bit becomes true.
- Stable resets to 0, so an input held high through reset produces a rising edge DEBOUNCE_CYCLES+2 cycles after reset release.
- Reset asserted mid-transfer or mid-debounce aborts everything immediately; there is no partial-state retention.

Optional Feature:
APB_GPIO_PWM_EN:
- Defined:
  - Adds PWM_DUTY at 0x18: RW, 8 bits, reset 0.
  - Adds an 8-bit free-running counter that wraps 255->0 and resets to 0.
  - gpio_out = OUT & {GPIO_WIDTH{cnt < PWM_DUTY}}, registered. Duty 0 turns all outputs off; duty 255 gives 255/256 on-time.
  - Exception: when PWM_DUTY=0 and the PWM_BYPASS bit (PWM_DUTY[8], reset 1) is set, gpio_out = OUT directly.
- Undefined: gpio_out = OUT directly; offset 0x18 is unmapped and gives pslverror=1.

Test Plan:
- Reset/readback: DEBOUNCE_CYCLES=4. After reset, read 0x00..0x14 -> all 0, irq=0. Write OUT=0xA5A5 -> gpio_out=0xA5A5 after the access cycle, readback 0xA5A5.
- Debounce: gpio_in[0] 0->1 held -> IN[0]=1 exactly 6 cycles later. A 3-cycle pulse on gpio_in[1] -> IN stays 0.
- Rising interrupt: RISE_EN=0x1, IRQ_EN=0x1, gpio_in[0] rises -> IRQ_STATUS=0x1, irq=1. Write 0x1 to 0x0C -> status 0, irq=0 the next cycle.
- Fall masked: FALL_EN=0, channel 2 falls -> IRQ_STATUS[2]=0. Set FALL_EN[2]=1 and repeat -> status bit set, irq stays 0 while IRQ_EN[2]=0.
- Set/clear collision: force a debounced edge on channel 3 in the same cycle as a W1C 0x8 write -> IRQ_STATUS[3]=1 afterwards.
- Error/PWM: read offset 0x1C -> pslverror=1, prdata=0.
  - With APB_GPIO_PWM_EN, OUT=0xFFFF and PWM_DUTY=64 -> gpio_out high for 64 of every 256 cycles.
  - Without APB_GPIO_PWM_EN, access to 0x18 -> pslverror=1.
